hamming_secded_serial_decoder: RTL and testbench

//  Serial-in, parallel-out extended-Hamming (SECDED) decoder, generalised in code size.
//  - Accepts one code bit per accepted beat, in ascending position order 0..N-1.
//  - Position 0 is the overall parity bit; positions 2^i are the check bits.
//  - Accumulates syndrome and overall parity on the fly, and stores the frame.
//  - Corrects a single error; flags double errors; presents the data word behind a valid/ready handshake.

---
 rtl/hamming_pkg.sv | 33 +++
 rtl/hamming_syndrome_acc.sv | 48 ++++
 rtl/hamming_secded_serial_decoder.sv | 168 ++++++++++++++++
 tb/tb_hamming_secded_serial_decoder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the serial SECDED decoder.
package hamming_pkg;

  typedef enum logic [1:0] {COLLECT, DECODE, HOLD} state_e;

  function automatic int n_of(input int r);
    return 1 << r;
  endfunction

  function automatic int k_of(input int r);
    return (1 << r) - r - 1;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Code position of data bit j: j-th non-power-of-two position starting at 3.
  function automatic int data_pos(input int j, input int r);
    int cnt;
    int found;
    cnt   = 0;
    found = 0;
    for (int p = 3; p < (1 << r); p++) begin
      if (!is_pow2(p)) begin
        if (cnt == j) found = p;
        cnt++;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/hamming_syndrome_acc.sv
// Serial syndrome / overall-parity accumulator; a bit landing at position 0
// (frame start or in_sof restart) reloads the state from that bit alone.
module hamming_syndrome_acc
  import hamming_pkg::*;
#(
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beat,
  input  logic         sof,
  input  logic         bit_in,
  input  logic [R-1:0] pos_in,
  output logic [R-1:0] syn,
  output logic         par
);

  logic [R-1:0] syn_q, syn_d;
  logic         par_q, par_d;

  always_comb begin
    syn_d = syn_q;
    par_d = par_q;
    if (beat) begin
      if (sof || pos_in == '0) begin
        syn_d = '0;
        par_d = bit_in;
      end else begin
        syn_d = bit_in ? (syn_q ^ pos_in) : syn_q;
        par_d = par_q ^ bit_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      syn_q <= '0;
      par_q <= 1'b0;
    end else begin
      syn_q <= syn_d;
      par_q <= par_d;
    end
  end

  assign syn = syn_q;
  assign par = par_q;

endmodule

// File: rtl/hamming_secded_serial_decoder.sv
// Serial-in extended-Hamming SECDED decoder: frame store, FSM, correction and
// data extraction. Define HAMMING_ERR_CNT_EN to add saturating error counters.
module hamming_secded_serial_decoder
  import hamming_pkg::*;
#(
  parameter int R     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic                 in_ready,
  output logic [k_of(R)-1:0]   data_out,
  output logic [R-1:0]         syndrome,
  output logic                 err_corrected,
  output logic                 err_uncorr,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef HAMMING_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]     cnt_corr,
  output logic [CNT_W-1:0]     cnt_uncorr
`endif
);

  localparam int N = n_of(R);
  localparam int K = k_of(R);

  if (CNT_W < 1) begin : g_cnt_w_illegal
  end

  state_e         state_q, state_d;
  logic [R-1:0]   pos_q, pos_d;
  logic [N-1:0]   mem_q, mem_d;
  logic [K-1:0]   data_q, data_d;
  logic [R-1:0]   syn_out_q, syn_out_d;
  logic           corr_q, corr_d;
  logic           uncorr_q, uncorr_d;
  logic           vld_q, vld_d;

  logic           beat;
  logic [R-1:0]   eff_pos;
  logic [R-1:0]   acc_syn;
  logic           acc_par;
  logic [N-1:0]   fixed_w;
  logic [K-1:0]   data_w;

  assign in_ready = (state_q == COLLECT);
  assign beat     = in_valid && in_ready;
  assign eff_pos  = in_sof ? '0 : pos_q;

  hamming_syndrome_acc #(.R(R)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .beat   (beat),
    .sof    (in_sof),
    .bit_in (in_bit),
    .pos_in (eff_pos),
    .syn    (acc_syn),
    .par    (acc_par)
  );

  // Odd overall parity means one error at position syn (0 = the parity bit).
  always_comb begin
    fixed_w = mem_q;
    if (acc_par) fixed_w[acc_syn] = ~mem_q[acc_syn];
  end

  for (genvar j = 0; j < K; j++) begin : g_extract
    assign data_w[j] = fixed_w[data_pos(j, R)];
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    mem_d     = mem_q;
    data_d    = data_q;
    syn_out_d = syn_out_q;
    corr_d    = corr_q;
    uncorr_d  = uncorr_q;
    vld_d     = vld_q;
    unique case (state_q)
      COLLECT: begin
        if (beat) begin
          mem_d[eff_pos] = in_bit;
          pos_d          = eff_pos + R'(1);
          if (eff_pos == '1) state_d = DECODE;
        end
      end
      DECODE: begin
        data_d    = data_w;
        syn_out_d = acc_syn;
        corr_d    = acc_par;
        uncorr_d  = !acc_par && (acc_syn != '0);
        vld_d     = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          vld_d    = 1'b0;
          corr_d   = 1'b0;
          uncorr_d = 1'b0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      pos_q     <= '0;
      mem_q     <= '0;
      data_q    <= '0;
      syn_out_q <= '0;
      corr_q    <= 1'b0;
      uncorr_q  <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      mem_q     <= mem_d;
      data_q    <= data_d;
      syn_out_q <= syn_out_d;
      corr_q    <= corr_d;
      uncorr_q  <= uncorr_d;
      vld_q     <= vld_d;
    end
  end

  assign data_out      = data_q;
  assign syndrome      = syn_out_q;
  assign err_corrected = corr_q;
  assign err_uncorr    = uncorr_q;
  assign out_valid     = vld_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;
  logic             hs;

  assign hs = vld_q && out_ready;

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (hs && corr_q && cnt_corr_q != '1)     cnt_corr_d   = cnt_corr_q + CNT_W'(1);
    if (hs && uncorr_q && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;
`endif

endmodule

// File: tb/tb_hamming_secded_serial_decoder.sv
// Directed bench for the serial SECDED decoder at R=4 (N=16, K=11).
module tb_hamming_secded_serial_decoder;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_bit, in_valid, in_sof, out_ready;
  logic        in_ready, err_corrected, err_uncorr, out_valid;
  logic [10:0] data_out;
  logic [3:0]  syndrome;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

`ifdef HAMMING_ERR_CNT_EN
  logic [15:0] cnt_corr, cnt_uncorr;
  logic        s_in_ready, s_corr, s_uncorr, s_valid;
  logic [10:0] s_data;
  logic [3:0]  s_syn;
  logic [1:0]  s_cnt_corr, s_cnt_uncorr;

  hamming_secded_serial_decoder #(.R(R), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(s_in_ready), .data_out(s_data), .syndrome(s_syn),
    .err_corrected(s_corr), .err_uncorr(s_uncorr), .out_valid(s_valid),
    .out_ready(out_ready), .cnt_corr(s_cnt_corr), .cnt_uncorr(s_cnt_uncorr)
  );
`endif

  hamming_secded_serial_decoder #(.R(R)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .data_out(data_out), .syndrome(syndrome),
    .err_corrected(err_corrected), .err_uncorr(err_uncorr), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef HAMMING_ERR_CNT_EN
    , .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus encoder: data into non-power-of-2 slots, check bits, then overall parity.
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] f;
    int j;
    f = '0;
    j = 0;
    for (int p = 1; p < 16; p++)
      if ((p & (p - 1)) != 0) begin
        f[p] = d[j];
        j++;
      end
    for (int i = 0; i < 4; i++)
      for (int p = 1; p < 16; p++)
        if (((p >> i) & 1) == 1 && p != (1 << i)) f[1 << i] ^= f[p];
    f[0] = ^f;
    return f;
  endfunction

  task automatic send_bit(input logic b, input logic sof);
    in_bit = b; in_sof = sof; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] f);
    for (int i = 0; i < 16; i++) send_bit(f[i], i == 0);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] f, input logic [10:0] ed,
                           input logic [3:0] es, input logic ec, input logic eu);
    send_frame(f);
    chk({tag, "_decode_vld"}, 32'(out_valid), 0);
    chk({tag, "_decode_rdy"}, 32'(in_ready), 0);
    @(posedge clk); #1;
    chk({tag, "_vld"},  32'(out_valid), 1);
    chk({tag, "_data"}, 32'(data_out), 32'(ed));
    chk({tag, "_syn"},  32'(syndrome), 32'(es));
    chk({tag, "_corr"}, 32'(err_corrected), 32'(ec));
    chk({tag, "_unc"},  32'(err_uncorr), 32'(eu));
    @(posedge clk); #1;
    chk({tag, "_after_hs"}, {30'd0, out_valid, in_ready}, 32'h1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"},  32'(in_ready), 1);
    chk({tag, "_vld"},  32'(out_valid), 0);
    chk({tag, "_data"}, 32'(data_out), 0);
    chk({tag, "_syn"},  32'(syndrome), 0);
    chk({tag, "_flags"}, {30'd0, err_corrected, err_uncorr}, 0);
  endtask

  initial begin
    logic [15:0] fa, fb, junk;
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    fa = enc(11'h5A3);
    run_frame("clean",    fa,                     11'h5A3, 4'd0, 1'b0, 1'b0);
    run_frame("flip7",    fa ^ 16'h0080,          11'h5A3, 4'd7, 1'b1, 1'b0);
    run_frame("flip0",    fa ^ 16'h0001,          11'h5A3, 4'd0, 1'b1, 1'b0);
    run_frame("flip3_5",  fa ^ 16'h0028,          11'h5A0, 4'd6, 1'b0, 1'b1);

    // Backpressure: result must sit still and input beats must be refused.
    fb = enc(11'h2C7);
    out_ready = 1'b0;
    send_frame(fb);
    @(posedge clk); #1;
    chk("hold_vld0", 32'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_sof = 1'b1; in_bit = 1'b1;
      @(posedge clk); #1;
      chk("hold_vld",  32'(out_valid), 1);
      chk("hold_rdy",  32'(in_ready), 0);
      chk("hold_data", 32'(data_out), 32'h2C7);
    end
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", {30'd0, out_valid, in_ready}, 32'h1);
    run_frame("post_hold", fa ^ 16'h1000, 11'h5A3, 4'd12, 1'b1, 1'b0);

    // Restart via in_sof at bit 9: the partial frame is dropped.
    junk = enc(11'h7FF) ^ 16'h0210;
    for (int i = 0; i < 9; i++) send_bit(junk[i], i == 0);
    chk("sof_no_vld", 32'(out_valid), 0);
    run_frame("sof_restart", enc(11'h135), 11'h135, 4'd0, 1'b0, 1'b0);

    // Reset mid-frame.
    for (int i = 0; i < 9; i++) send_bit(junk[i], i == 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("midrst");
    run_frame("after_rst", enc(11'h0F0), 11'h0F0, 4'd0, 1'b0, 1'b0);

`ifdef HAMMING_ERR_CNT_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame("c1", fa ^ 16'h0080, 11'h5A3, 4'd7,  1'b1, 1'b0);
    run_frame("c2", fa ^ 16'h0001, 11'h5A3, 4'd0,  1'b1, 1'b0);
    run_frame("c3", fa ^ 16'h1000, 11'h5A3, 4'd12, 1'b1, 1'b0);
    run_frame("u1", fa ^ 16'h0028, 11'h5A0, 4'd6,  1'b0, 1'b1);
    run_frame("u2", fa ^ 16'h0006, 11'h5A3, 4'd3,  1'b0, 1'b1);
    chk("cnt_corr",     32'(cnt_corr), 3);
    chk("cnt_uncorr",   32'(cnt_uncorr), 2);
    chk("s_cnt_corr",   32'(s_cnt_corr), 3);
    chk("s_cnt_uncorr", 32'(s_cnt_uncorr), 2);
    run_frame("c4", fa ^ 16'h0080, 11'h5A3, 4'd7, 1'b1, 1'b0);
    run_frame("c5", fa ^ 16'h0001, 11'h5A3, 4'd0, 1'b1, 1'b0);
    chk("cnt_corr5",   32'(cnt_corr), 5);
    chk("s_cnt_sat",   32'(s_cnt_corr), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
